// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: datapath sizing, result-select encoding and
// the saturating pending-count helper used by the scoreboard.
package wb_regfile_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned REGW  = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    // Offset by 2 so the sum of one increment and up to two decrements
    // never underflows, then clamp into 0..3.
    function automatic logic [1:0] next_count(input logic [1:0] c,
                                              input logic       inc,
                                              input logic       dec_a,
                                              input logic       dec_b);
        logic [3:0] s;
        s = {2'b00, c} + {3'b000, inc} + 4'd2 - {3'b000, dec_a} - {3'b000, dec_b};
        if (s < 4'd2) return 2'd0;
        if (s > 4'd5) return 2'd3;
        return 2'(s - 4'd2);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters and source Busy flags for decode.
module wb_scoreboard
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREGS = wb_regfile_pkg::NREGS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IssueD,
    input  logic [4:0]  RdD,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic        FlushE,
    input  logic        RegWriteE,
    input  logic [4:0]  RdE,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    output logic        BusyRs1D,
    output logic        BusyRs2D
);

    logic [NREGS-1:1][1:0] cnt;
    logic [NREGS-1:1][1:0] cnt_nxt;
    logic [31:0]           busy_vec;

    always_comb begin
        cnt_nxt  = cnt;
        busy_vec = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            cnt_nxt[i] = next_count(cnt[i],
                                    IssueD && (RdD == 5'(i)),
                                    RegWriteW && (RdW == 5'(i)),
                                    FlushE && RegWriteE && (RdE == 5'(i)));
            // A write retiring this cycle already counts as visible.
            busy_vec[i] = (cnt[i] > 2'd1) ||
                          ((cnt[i] == 2'd1) && !(RegWriteW && (RdW == 5'(i))));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign BusyRs1D = busy_vec[Rs1D];
    assign BusyRs2D = busy_vec[Rs2D];

endmodule

// File: rtl/wb_regfile.sv
// Writeback result mux, architectural register file with write-through reads,
// and the pending-write scoreboard for decode-stage hazard detection.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned XLEN  = wb_regfile_pkg::XLEN,
    parameter int unsigned NREGS = wb_regfile_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ResultW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    input  logic            IssueD,
    input  logic [4:0]      RdD,
    input  logic            FlushE,
    input  logic            RegWriteE,
    input  logic [4:0]      RdE,
    output logic            BusyRs1D,
    output logic            BusyRs2D
);

    logic [NREGS-1:1][XLEN-1:0] regs;
    logic                       wr_en;

    always_comb begin
        ResultW = '0;
        case (res_src_e'(ResultSrcW))
            RES_ALU: ResultW = ALUResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    assign wr_en = RegWriteW && (RdW != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[RdW] <= ResultW;
        end
    end

    // Reset gating keeps the bypass path from leaking ResultW while in reset.
    always_comb begin
        RD1D = '0;
        if (reset && (Rs1D != '0)) begin
            if (wr_en && (RdW == Rs1D)) RD1D = ResultW;
            else                        RD1D = regs[Rs1D];
        end
    end

    always_comb begin
        RD2D = '0;
        if (reset && (Rs2D != '0)) begin
            if (wr_en && (RdW == Rs2D)) RD2D = ResultW;
            else                        RD2D = regs[Rs2D];
        end
    end

    wb_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .IssueD    (IssueD),
        .RdD       (RdD),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .FlushE    (FlushE),
        .RegWriteE (RegWriteE),
        .RdE       (RdE),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .BusyRs1D  (BusyRs1D),
        .BusyRs2D  (BusyRs2D)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: result mux, write/bypass,
// x0 handling, scoreboard counting/saturation and asynchronous reset.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        IssueD;
    logic [4:0]  RdD;
    logic        FlushE;
    logic        RegWriteE;
    logic [4:0]  RdE;
    logic        BusyRs1D;
    logic        BusyRs2D;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .ResultW    (ResultW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .IssueD     (IssueD),
        .RdD        (RdD),
        .FlushE     (FlushE),
        .RegWriteE  (RegWriteE),
        .RdE        (RdE),
        .BusyRs1D   (BusyRs1D),
        .BusyRs2D   (BusyRs2D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset      = 1'b0;
        RegWriteW  = 1'b0;
        ResultSrcW = 2'b00;
        RdW        = 5'd0;
        ALUResultW = 32'h0000_BEEF;
        ReadDataW  = 32'h0;
        PCPlus4W   = 32'h0;
        Rs1D       = 5'd5;
        Rs2D       = 5'd0;
        IssueD     = 1'b0;
        RdD        = 5'd0;
        FlushE     = 1'b0;
        RegWriteE  = 1'b0;
        RdE        = 5'd0;

        #3;
        check("rst_rd1",    RD1D, 32'h0);
        check("rst_busy1",  32'(BusyRs1D), 32'h0);
        check("rst_result", ResultW, 32'h0000_BEEF);

        step();
        step();
        reset = 1'b1;

        // Write x5 with same-cycle bypass on port 2
        RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'h1234; Rs2D = 5'd5;
        #1;
        check("wr_result",  ResultW, 32'h1234);
        check("bypass_rd2", RD2D, 32'h1234);
        check("pre_wr_rd1", RD1D, 32'h1234);
        step();
        RegWriteW = 1'b0; Rs2D = 5'd0;
        #1;
        check("x5_rd1", RD1D, 32'h1234);
        check("x0_rd2", RD2D, 32'h0);

        // Write to x0 is discarded
        RegWriteW = 1'b1; RdW = 5'd0; ALUResultW = 32'hFFFF; Rs1D = 5'd0; Rs2D = 5'd5;
        #1;
        check("x0_bypass", RD1D, 32'h0);
        check("x0_busy",   32'(BusyRs1D), 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        check("x0_after", RD1D, 32'h0);
        check("x5_kept",  RD2D, 32'h1234);

        // Result mux selections
        ResultSrcW = 2'b01; ReadDataW = 32'hA5A5_A5A5;
        #1 check("mux_mem", ResultW, 32'hA5A5_A5A5);
        ResultSrcW = 2'b10; PCPlus4W = 32'h104;
        #1 check("mux_pc4", ResultW, 32'h104);
        ResultSrcW = 2'b11;
        #1 check("mux_zero", ResultW, 32'h0);
        ResultSrcW = 2'b10; RegWriteW = 1'b1; RdW = 5'd6;
        step();
        RegWriteW = 1'b0; Rs1D = 5'd6; ResultSrcW = 2'b00;
        #1 check("x6_pc4", RD1D, 32'h104);

        // Issue x7, retire three cycles later, then an excess retire
        Rs1D = 5'd7; IssueD = 1'b1; RdD = 5'd7;
        #1 check("x7_c0", 32'(BusyRs1D), 32'h0);
        step();
        IssueD = 1'b0;
        #1 check("x7_c1", 32'(BusyRs1D), 32'h1);
        step();
        #1 check("x7_c2", 32'(BusyRs1D), 32'h1);
        step();
        RegWriteW = 1'b1; RdW = 5'd7; ALUResultW = 32'h77;
        #1 check("x7_c3", 32'(BusyRs1D), 32'h0);
        step();
        #1 check("x7_c4", 32'(BusyRs1D), 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        check("x7_no_underflow", 32'(BusyRs1D), 32'h0);
        check("x7_value", RD1D, 32'h77);

        // Two issues of x9, third issue paired with a flush of x9 -> count 2
        Rs1D = 5'd9; Rs2D = 5'd9; IssueD = 1'b1; RdD = 5'd9;
        step();
        step();
        FlushE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9;
        #1 check("x9_cnt2", 32'(BusyRs1D), 32'h1);
        step();
        IssueD = 1'b0; FlushE = 1'b0; RegWriteE = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd9;
        #1 check("x9_ret_of2", 32'(BusyRs2D), 32'h1);
        step();
        #1 check("x9_ret_of1", 32'(BusyRs2D), 32'h0);
        step();
        RegWriteW = 1'b0;
        #1 check("x9_empty", 32'(BusyRs1D), 32'h0);

        // Four issues of x10 saturate the counter at 3
        Rs1D = 5'd10; IssueD = 1'b1; RdD = 5'd10;
        step(); step(); step(); step();
        IssueD = 1'b0; RegWriteW = 1'b1; RdW = 5'd10;
        #1 check("sat_ret_of3", 32'(BusyRs1D), 32'h1);
        step();
        #1 check("sat_ret_of2", 32'(BusyRs1D), 32'h1);
        step();
        #1 check("sat_ret_of1", 32'(BusyRs1D), 32'h0);
        step();
        RegWriteW = 1'b0;
        #1 check("sat_empty", 32'(BusyRs1D), 32'h0);

        // Issue, retire and flush on x11 in one cycle sum to -1
        Rs1D = 5'd11; IssueD = 1'b1; RdD = 5'd11;
        step();
        RegWriteW = 1'b1; RdW = 5'd11; FlushE = 1'b1; RegWriteE = 1'b1; RdE = 5'd11;
        #1 check("sum_same_cycle", 32'(BusyRs1D), 32'h0);
        step();
        IssueD = 1'b0; RegWriteW = 1'b0; FlushE = 1'b0; RegWriteE = 1'b0;
        #1 check("sum_result", 32'(BusyRs1D), 32'h0);

        // Asynchronous reset while x3 holds data and a pending write
        RegWriteW = 1'b1; RdW = 5'd3; ResultSrcW = 2'b00; ALUResultW = 32'h55;
        step();
        RegWriteW = 1'b0; IssueD = 1'b1; RdD = 5'd3;
        step();
        IssueD = 1'b0; Rs1D = 5'd3;
        #1;
        check("x3_loaded", RD1D, 32'h55);
        check("x3_busy",   32'(BusyRs1D), 32'h1);
        #2;
        reset = 1'b0; RegWriteW = 1'b1; RdW = 5'd3; ALUResultW = 32'h77;
        #1;
        check("arst_rd1",    RD1D, 32'h0);
        check("arst_busy",   32'(BusyRs1D), 32'h0);
        check("arst_result", ResultW, 32'h77);
        RegWriteW = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("post_rst_rd1",  RD1D, 32'h0);
        check("post_rst_busy", 32'(BusyRs1D), 32'h0);
        step();
        #1;
        check("post_edge_rd1",  RD1D, 32'h0);
        check("post_edge_busy", 32'(BusyRs1D), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
